// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Flag bit positions and opcodes shared by the ALU and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int FLAG_W        = 4;
    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : alu_fifo_mem
// Purpose  : DEPTH x (WIDTH+4) register array, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(DEPTH)-1:0]     i_waddr,
    input  logic [WIDTH+FLAG_W-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0]     i_raddr,
    output logic [WIDTH+FLAG_W-1:0]      o_rdata
);

    // Storage is deliberately left unreset; occupancy tracking makes it safe.
    logic [WIDTH+FLAG_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Purpose  : Show-ahead FIFO for ALU results with saturating ERR/OVF counters.
//            Define ALU_FIFO_DROP_ERR_EN to count but not store ERR results.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_result,
    input  logic [FLAG_W-1:0]          i_flag,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_result,
    output logic [FLAG_W-1:0]          o_flag,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic [CNT_W-1:0]           o_ovf_cnt
);

    localparam int                 AW     = $clog2(DEPTH);
    localparam logic [AW:0]        c_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_count;
    logic [CNT_W-1:0]          r_err_cnt;
    logic [CNT_W-1:0]          r_ovf_cnt;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_write;
    logic                      w_pop;
    logic [WIDTH+FLAG_W-1:0]   w_rdata;

    // Handshake outputs depend only on registered occupancy.
    assign o_ready  = (r_count != c_FULL);
    assign o_valid  = (r_count != '0);
    assign w_accept = i_valid && o_ready;
    assign w_pop    = o_valid && i_ready;

`ifdef ALU_FIFO_DROP_ERR_EN
    assign w_drop = i_flag[FLAG_ERR];
`else
    assign w_drop = 1'b0;
`endif

    assign w_write = w_accept && !w_drop;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_write && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // Counters see every accepted input, including dropped ERR ones.
            if (w_accept && i_flag[FLAG_ERR] && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (w_accept && i_flag[FLAG_OVERFLOW] && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    alu_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata ({i_flag, i_result}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign o_result  = w_rdata[WIDTH-1:0];
    assign o_flag    = w_rdata[WIDTH+FLAG_W-1:WIDTH];
    assign o_count   = r_count;
    assign o_err_cnt = r_err_cnt;
    assign o_ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_fifo
// Purpose  : Directed and random checks of alu_result_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_fifo;

    localparam int WIDTH   = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               i_clk    = 1'b0;
    logic               i_rstn   = 1'b0;
    logic               i_valid  = 1'b0;
    logic [WIDTH-1:0]   i_result = '0;
    logic [3:0]         i_flag   = '0;
    logic               i_ready  = 1'b0;
    logic               o_ready;
    logic               o_valid;
    logic [WIDTH-1:0]   o_result;
    logic [3:0]         o_flag;
    logic [2:0]         o_count;
    logic [CNT_W-1:0]   o_err_cnt;
    logic [CNT_W-1:0]   o_ovf_cnt;

    logic [7:0] q[$];
    int         err_m   = 0;
    int         ovf_m   = 0;
    int         n_pass  = 0;
    int         n_total = 0;

    alu_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_valid   (i_valid),
        .i_result  (i_result),
        .i_flag    (i_flag),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_result  (o_result),
        .o_flag    (o_flag),
        .i_ready   (i_ready),
        .o_count   (o_count),
        .o_err_cnt (o_err_cnt),
        .o_ovf_cnt (o_ovf_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(o_count), 32'(q.size()));
        check({tag, ".valid"}, 32'(o_valid), 32'(q.size() != 0));
        check({tag, ".ready"}, 32'(o_ready), 32'(q.size() != DEPTH));
        if (q.size() != 0) begin
            check({tag, ".result"}, 32'(o_result), 32'(q[0][3:0]));
            check({tag, ".flag"},   32'(o_flag),   32'(q[0][7:4]));
        end
        check({tag, ".err"}, 32'(o_err_cnt), 32'(err_m));
        check({tag, ".ovf"}, 32'(o_ovf_cnt), 32'(ovf_m));
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic cycle(input logic v, input logic [3:0] res, input logic [3:0] flg,
                         input logic rdy, input string tag);
        bit acc;
        bit pop;
        bit store;
        i_valid  = v;
        i_result = res;
        i_flag   = flg;
        i_ready  = rdy;
        acc = v && (q.size() != DEPTH);
        pop = rdy && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (flg[0] && err_m < CNT_MAX) err_m++;
            if (flg[3] && ovf_m < CNT_MAX) ovf_m++;
            store = 1'b1;
`ifdef ALU_FIFO_DROP_ERR_EN
            if (flg[0]) store = 1'b0;
`endif
            if (store) q.push_back({flg, res});
        end
        @(posedge i_clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        logic [3:0] fill_vals [4] = '{4'd4, 4'd14, 4'd2, 4'd6};

        // Reset state, released between clock edges.
        #12;
        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.ready", 32'(o_ready), 32'd1);
        check("rst.count", 32'(o_count), 32'd0);
        check("rst.err",   32'(o_err_cnt), 32'd0);
        check("rst.ovf",   32'(o_ovf_cnt), 32'd0);
        i_rstn = 1'b1;

        // Single write, one-cycle latency to the head.
        cycle(1'b1, 4'd4, 4'b0100, 1'b0, "single");
        check("single.result", 32'(o_result), 32'd4);
        check("single.flag",   32'(o_flag),   32'b0100);
        check("single.count",  32'(o_count),  32'd1);
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "single_drain");

        // Fill to full, overflow push ignored, drain in order.
        foreach (fill_vals[i]) cycle(1'b1, fill_vals[i], 4'b0000, 1'b0, "fill");
        check("full.count", 32'(o_count), 32'd4);
        check("full.ready", 32'(o_ready), 32'd0);
        cycle(1'b1, 4'd7, 4'b0000, 1'b0, "fifth_push");
        check("fifth.count", 32'(o_count), 32'd4);
        foreach (fill_vals[i]) begin
            check("drain.order", 32'(o_result), 32'(fill_vals[i]));
            cycle(1'b0, 4'd0, 4'b0000, 1'b1, "drain");
        end
        check("drained.valid", 32'(o_valid), 32'd0);

        // Simultaneous accept and pop at count 2; write pointer wraps past 3.
        cycle(1'b1, 4'd1, 4'b0000, 1'b0, "pre_simul");
        cycle(1'b1, 4'd2, 4'b0000, 1'b0, "pre_simul");
        cycle(1'b1, 4'd3, 4'b0000, 1'b1, "simul");
        check("simul.count", 32'(o_count), 32'd2);
        check("simul.head",  32'(o_result), 32'd2);
        cycle(1'b1, 4'd8, 4'b0000, 1'b1, "simul_wrap");
        check("wrap.count", 32'(o_count), 32'd2);
        check("wrap.head",  32'(o_result), 32'd3);
        cycle(1'b1, 4'd0, 4'b0000, 1'b1, "full_pop");
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "drain2");
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "drain2");
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "drain2");

        // Push while full with a pop in the same cycle: pop only.
        repeat (4) cycle(1'b1, 4'd5, 4'b0000, 1'b0, "refill");
        cycle(1'b1, 4'd9, 4'b0000, 1'b1, "full_simul");
        check("full_simul.count", 32'(o_count), 32'd3);
        repeat (3) cycle(1'b0, 4'd0, 4'b0000, 1'b1, "drain3");
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "empty_pop");

        // ERR entry followed by an OVERFLOW entry.
        cycle(1'b1, 4'd0, 4'b0001, 1'b0, "err_in");
        cycle(1'b1, 4'd5, 4'b1000, 1'b0, "ovf_in");
        check("errin.err", 32'(o_err_cnt), 32'd1);
        check("errin.ovf", 32'(o_ovf_cnt), 32'd1);
`ifdef ALU_FIFO_DROP_ERR_EN
        check("errin.count", 32'(o_count),  32'd1);
        check("errin.head",  32'(o_result), 32'd5);
`else
        check("errin.count", 32'(o_count),  32'd2);
        check("errin.head",  32'(o_result), 32'd0);
`endif

        // Asynchronous reset mid-operation.
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "pre_mid");
        cycle(1'b0, 4'd0, 4'b0000, 1'b1, "pre_mid");
        repeat (3) cycle(1'b1, 4'd6, 4'b0000, 1'b0, "pre_mid_fill");
        check("mid.count3", 32'(o_count), 32'd3);
        i_valid = 1'b0;
        #2;
        i_rstn = 1'b0;
        #1;
        check("midrst.valid", 32'(o_valid), 32'd0);
        check("midrst.count", 32'(o_count), 32'd0);
        q.delete();
        err_m = 0;
        ovf_m = 0;
        check_state("midrst");
        #3;
        i_rstn = 1'b1;
        cycle(1'b1, 4'd9, 4'b0000, 1'b0, "post_rst");
        check("post_rst.head", 32'(o_result), 32'd9);

        // Random traffic; long enough for both counters to saturate.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), "rnd");
        end
        check("sat.err", 32'(o_err_cnt), 32'(CNT_MAX));
        check("sat.ovf", 32'(o_ovf_cnt), 32'(CNT_MAX));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
- REQ-001 SHALL have parameter WIDTH, default 4: result width, matching the ALU WIDTH.
- REQ-002 SHALL have parameter DEPTH, default 4: number of entries; must be a power of 2, minimum 2.
- REQ-003 SHALL have parameter CNT_W, default 8: width of the event counters.
- REQ-004 SHALL use one clock and an asynchronous active-low reset, as the ports below.
- REQ-005 i_clk  in  1  clock; all state changes on the rising edge.
- REQ-006 i_rstn  in  1  asynchronous reset, active low.
- REQ-007 i_valid  in  1  ALU result valid this cycle.
- REQ-008 i_result  in  WIDTH  signed ALU result (o_result of the ALU stage).
- REQ-009 i_flag  in  4  ALU flags: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
- REQ-010 o_ready  out  1  FIFO can accept a write.
- REQ-011 o_valid  out  1  head entry available.
- REQ-012 o_result  out  WIDTH  head entry result.
- REQ-013 o_flag  out  4  head entry flags.
- REQ-014 i_ready  in  1  consumer accepts the head entry.
- REQ-015 o_count  out  log2(DEPTH)+1  current occupancy.
- REQ-016 o_err_cnt  out  CNT_W  saturating count of accepted inputs with ERR=1.
- REQ-017 o_ovf_cnt  out  CNT_W  saturating count of accepted inputs with OVERFLOW=1.

Function
- REQ-018 An input SHALL be accepted when i_valid && o_ready.
- REQ-019 The head SHALL be popped when o_valid && i_ready.
- REQ-020 o_ready SHALL equal (o_count != DEPTH), and o_valid SHALL equal (o_count != 0); both are registered-state derived, with no combinational path from i_ready or i_valid.
- REQ-021 The FIFO is show-ahead: o_result and o_flag SHALL present the head entry whenever o_valid=1. Their value while o_valid=0 is don't-care.
- REQ-022 Write-to-output latency SHALL be 1 cycle: data accepted at edge N is visible at the head after edge N when the FIFO was empty. There is no same-cycle bypass.
- REQ-023 On a simultaneous accept and pop, o_count SHALL be unchanged, and both pointers SHALL advance.
- REQ-024 When full, i_valid SHALL be ignored even if i_ready=1 in the same cycle; the pop still occurs.
- REQ-025 When empty, i_ready SHALL be ignored.
- REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-027 Output order SHALL be strict FIFO (first in, first out).
- REQ-028 o_err_cnt and o_ovf_cnt SHALL increment by 1 per accepted flagged input and hold at 2^CNT_W-1.
- REQ-029 The counters SHALL update in the same edge as the accept.

Reset
- REQ-030 While i_rstn=0, the block SHALL asynchronously clear the pointers, o_count, o_err_cnt and o_ovf_cnt.
- REQ-031 Resulting output values during and after reset: o_valid=0, o_ready=1, o_count=0.
- REQ-032 Storage contents SHALL NOT be reset.
- REQ-033 A reset mid-operation SHALL discard all stored entries. The first accept after release is the new head.

Configuration
- REQ-034 Macro ALU_FIFO_DROP_ERR_EN defined: an accepted input with ERR=1 SHALL be counted in o_err_cnt but SHALL NOT be written. o_count and the pointers SHALL be unchanged by it.
- REQ-035 Macro ALU_FIFO_DROP_ERR_EN undefined: ERR entries SHALL be stored like any other entry and still be counted.

Structure
- REQ-036 Flag bit positions (FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3) and the ALU opcode constants SHALL live in shared package alu_pkg, used by both the ALU TOP and this block.
- REQ-037 Storage SHALL be one sub-module, alu_fifo_mem: a DEPTH x (WIDTH+4) register array with synchronous write and asynchronous read.
- REQ-038 Pointer, count and counter logic SHALL stay in alu_result_fifo.

Verification (WIDTH=4, DEPTH=4)
- REQ-039 Reset check: i_rstn=0 -> o_valid=0, o_ready=1, o_count=0, o_err_cnt=0, o_ovf_cnt=0.
- REQ-040 Single write: push result 4'd4, flag 4'b0100, with i_ready=0 -> on the next cycle o_valid=1, o_result=4, o_flag=0100, o_count=1.
- REQ-041 Fill and drain:
  - Push 4, 14, 2, 6 with i_ready=0 -> o_count=4, o_ready=0.
  - A 5th push of 7 is ignored.
  - Drain with i_ready=1 -> the bench sees 4, 14, 2, 6 in order, then o_valid=0.
- REQ-042 Simultaneous accept and pop at o_count=2 -> o_count stays 2 and the head advances. Also run this with pointer wrap past entry 3.
- REQ-043 Error input: push result 0, flag 4'b0001, then result 5, flag 4'b1000:
  - ALU_FIFO_DROP_ERR_EN defined -> o_count=1, head=5, o_err_cnt=1, o_ovf_cnt=1.
  - Macro undefined -> o_count=2, head=0.
- REQ-044 Reset mid-operation: at o_count=3, assert i_rstn=0 between clock edges -> o_valid=0 and o_count=0 immediately. After release, push 9 -> head=9.
